// File: rtl/rr_mux_n_pkg.sv
// Shared constants for the channel mux: mode encodings and the index-width helper.
package rr_mux_n_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Returns ceil(log2(v)); used to size channel indices.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// Channel-input / single-output bus of the round-robin mux.
interface rr_mux_n_if
  import rr_mux_n_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 8
);
  localparam int unsigned SEL_W = clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  mode_e              mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/rr_mux_n_pick.sv
// Combinational round-robin search: first requester after ptr, wrapping through ptr.
module rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!gnt_vld && req[SEL_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel mux with fixed-select or round-robin grant and a one-item output register.
module rr_mux_n
  import rr_mux_n_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 8
) (
  input logic        clk,
  input logic        rst,
  rr_mux_n_if.slave  bus
);
  localparam int unsigned SEL_W = clog2(N);

  logic             load_en;
  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [N-1:0]     rdy;
  logic             xfer;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] src_q,   src_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  assign load_en = !valid_q || bus.out_ready;

  always_comb begin
    if (bus.mode == MODE_RR) begin
      gnt_vld = pick_vld;
      gnt_idx = pick_idx;
    end else begin
      gnt_vld = (32'(bus.sel) < N);
      gnt_idx = bus.sel;
    end
  end

  // Ready is gated by reset so nothing is accepted while the stage is being cleared.
  always_comb begin
    rdy = '0;
    if (!rst && gnt_vld && load_en) rdy = N'(1) << gnt_idx;
  end

  assign xfer = |(bus.in_valid & rdy);

  always_comb begin
    gnt_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (SEL_W'(k) == gnt_idx) gnt_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = gnt_data;
      src_d   = gnt_idx;
      if (bus.mode == MODE_RR) ptr_d = gnt_idx;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= SEL_W'(N - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n (N=8 and N=6 instances) with an expected-item scoreboard.
module tb_rr_mux_n;
  import rr_mux_n_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned N6 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_mux_n_if #(.WIDTH(W), .N(N))  bus  ();
  rr_mux_n_if #(.WIDTH(W), .N(N6)) bus6 ();

  rr_mux_n #(.WIDTH(W), .N(N))  dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  rr_mux_n #(.WIDTH(W), .N(N6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  src;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] chdat(input int k);
    if (k == 3) return 16'hBEEF;
    return 16'hA000 | 16'(k << 4) | 16'(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input mode_e m, input logic [2:0] s, input logic [7:0] v, input logic ordy);
    bus.mode      = m;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.out_ready = ordy;
  endtask

  task automatic chk_rdy(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, 32'(bus.in_ready), 32'(exp));
  endtask

  task automatic push_exp(input int k);
    sb.push_back({chdat(k), 3'(k)});
  endtask

  task automatic tick();
    item_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_data",  32'(bus.out_data),  32'(e.data));
      chk("out_src",   32'(bus.out_src),   32'(e.src));
    end
  endtask

  initial begin
    for (int k = 0; k < int'(N); k++)  bus.in_data[k*W +: W]  = chdat(k);
    for (int k = 0; k < int'(N6); k++) bus6.in_data[k*W +: W] = chdat(k);
    bus6.mode      = MODE_FIXED;
    bus6.sel       = 3'd7;
    bus6.in_valid  = 6'h3F;
    bus6.out_ready = 1'b1;

    // Reset with full RR demand present
    drive(MODE_RR, 3'd0, 8'hFF, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_src",   32'(bus.out_src),   32'd0);
    chk_rdy("rst_in_ready", 8'h00);
    chk("rst_in_ready6", 32'(bus6.in_ready), 32'd0);
    rst = 1'b0;

    // Fixed mode, sel=3
    drive(MODE_FIXED, 3'd3, 8'h08, 1'b1);
    chk_rdy("fix3_rdy", 8'h08);
    chk("n6_sel7_rdy", 32'(bus6.in_ready), 32'd0);
    push_exp(3);
    tick();
    drive(MODE_FIXED, 3'd3, 8'h00, 1'b1);
    chk_rdy("fix3_idle_rdy", 8'h08);
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("n6_sel7_valid", 32'(bus6.out_valid), 32'd0);

    // RR with all valid: 0..7 then 0, back to back
    drive(MODE_RR, 3'd0, 8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      chk_rdy("rr_all_rdy", 8'(1 << (i % 8)));
      push_exp(i % 8);
      tick();
    end

    // Wrap-around with ptr=0 and channels 7/0 valid
    drive(MODE_RR, 3'd0, 8'h81, 1'b1);
    chk_rdy("wrap_rdy_a", 8'h80); push_exp(7); tick();
    chk_rdy("wrap_rdy_b", 8'h01); push_exp(0); tick();
    chk_rdy("wrap_rdy_c", 8'h80); push_exp(7); tick();

    // Backpressure holds the ch7 item; release loads the next grant
    drive(MODE_RR, 3'd0, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_rdy("stall_rdy", 8'h00);
      tick();
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data",  32'(bus.out_data),  32'(chdat(7)));
      chk("stall_src",   32'(bus.out_src),   32'd7);
    end
    drive(MODE_RR, 3'd0, 8'hFF, 1'b1);
    chk_rdy("unstall_rdy", 8'h01);
    push_exp(0);
    tick();

    // Fixed transfer must leave ptr at 0, so RR resumes at 1
    drive(MODE_FIXED, 3'd5, 8'h20, 1'b1);
    chk_rdy("fix5_rdy", 8'h20); push_exp(5); tick();
    drive(MODE_RR, 3'd0, 8'hFF, 1'b1);
    chk_rdy("ptr_kept_rdy", 8'h02); push_exp(1); tick();

    drive(MODE_RR, 3'd0, 8'h00, 1'b1);
    chk_rdy("rr_none_rdy", 8'h00);
    tick();
    chk("empty_valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream discards the held item
    drive(MODE_RR, 3'd0, 8'hFF, 1'b1);
    chk_rdy("pre_rst_rdy", 8'h04); push_exp(2); tick();
    rst = 1'b1;
    drive(MODE_RR, 3'd0, 8'hFF, 1'b0);
    chk_rdy("in_rst_rdy", 8'h00);
    tick();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_src",   32'(bus.out_src),   32'd0);
    chk("mid_rst_data",  32'(bus.out_data),  32'd0);
    rst = 1'b0;
    drive(MODE_RR, 3'd0, 8'h24, 1'b1);
    chk_rdy("post_rst_rdy", 8'h04); push_exp(2); tick();

    // N=6 instance: in-range select works
    chk("n6_sel7_valid_end", 32'(bus6.out_valid), 32'd0);
    bus6.sel = 3'd5;
    #1;
    chk("n6_sel5_rdy", 32'(bus6.in_ready), 32'h20);
    tick();
    chk("n6_sel5_valid", 32'(bus6.out_valid), 32'd1);
    chk("n6_sel5_data",  32'(bus6.out_data),  32'(chdat(5)));
    chk("n6_sel5_src",   32'(bus6.out_src),   32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
